busy_ctr_arbiter: RTL
=====================

# busy_ctr_arbiter

Round-robin scheduler that shares one BusyCtr-style busy timer between NUM_REQ requesters. Requesters post a one-cycle request. The arbiter picks one pending requester, fires the timer's start method, and tracks the timer's busy output until it drops. It then pulses a per-requester done. It sits between client logic and a single BusyCtr instance, so the timer's one-shot resource is serialized.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- WDOG_LIMIT, default 64: watchdog expiry, in cycles; only used with the watchdog macro.
- CLK  in  1  clock; all state changes on its rising edge.
- nRST  in  1  reset; asynchronous and active-low.
- req__ENA  in  NUM_REQ  per-requester request strobe; honoured only when the matching req__RDY bit is high.
- req__RDY  out  NUM_REQ  bit i = !pending[i].
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- grantId  out  $clog2(NUM_REQ)  index of the current or most recent grant.
- start__ENA  out  1  fires the timer's start method.
- start__RDY  in  1  timer is idle (counter == 0).
- busy  in  1  timer busy output.
- error  out  1  sticky watchdog flag.

## Operation
- pending[i] is set at the edge where req__ENA[i] && req__RDY[i] is true.
- pending[i] is cleared at the edge that raises done[i].
- A request is never lost or duplicated.
- States:
  - IDLE: if any pending bit is set, choose the winner, register it into grantId, go to ISSUE.
    - Search starts at lastGrant+1 modulo NUM_REQ and wraps around.
  - ISSUE: start__ENA = start__RDY. At the edge where start__ENA is high, go to WAIT. If start__RDY is low, stay in ISSUE.
  - WAIT: lasts exactly one cycle.
    - busy high → RUN.
    - busy low (zero-length timer) → completion.
  - RUN: stay while busy is high. First cycle with busy low → completion.
- Completion, at one edge:
  - done[grantId] is high for the next cycle.
  - pending[grantId] clears.
  - lastGrant = grantId.
  - state → IDLE.
- start__ENA is decoded combinationally from the state. It is never high outside ISSUE.
- A requester may re-request in the cycle after its done pulse; req__RDY is high again then.
- Reset values:
  - state IDLE.
  - pending all 0; req__RDY all 1.
  - done 0, start__ENA 0, error 0.
  - grantId 0.
  - lastGrant NUM_REQ-1, so the first search starts at index 0.
- Reset mid-operation aborts the grant immediately: start__ENA drops asynchronously, and no done pulse is issued for the aborted grant.

## Timing
- Edge 0 accepts a request while idle. Then:
  - pending is visible in cycle 1.
  - ISSUE is entered in cycle 2; start__ENA is high in cycle 2 if start__RDY is high.
- With a BusyCtr of MAX_AMOUNT=M > 1:
  - busy is high for cycles 3..M+1.
  - RUN observes busy low in cycle M+2.
  - done is high in cycle M+3.
- Back-to-back grants: the next ISSUE comes 1 cycle after a done, i.e. 2 cycles of dead time per grant.
- Simultaneous requests all latch; they are served in round-robin order.
- A request from the requester currently granted cannot occur, because its req__RDY is low.

## Configuration
- BUSY_ARB_WATCHDOG_EN defined:
  - A cycle counter clears on entry to WAIT and increments in WAIT and RUN.
  - When the counter reaches WDOG_LIMIT, completion is forced: done[grantId] pulses and error sets.
  - error stays set until nRST.
- BUSY_ARB_WATCHDOG_EN undefined:
  - There is no counter and error is tied to 0.
  - RUN waits indefinitely for busy to drop.

## Test plan
- Reset: assert nRST=0 mid-RUN → start__ENA 0 and req__RDY all 1 immediately; grantId=0 after release; no done pulse.
- Single request: req__ENA[2] at edge 0, timer M=22 → start__ENA in cycle 2, done[2] in cycle 25 only, req__RDY[2] back to 1 in cycle 25.
- Contention: all four requests at edge 0 → done pulses in order 0,1,2,3, each 1 cycle long, consecutive starts 24 cycles apart.
- Round-robin fairness: after grant 1 completes, pending {0,3} → grant 3 next, then 0.
- Stalled timer: hold start__RDY=0 for 5 cycles in ISSUE → start__ENA stays 0, then fires on the first cycle start__RDY=1; latency extends by exactly 5.
- Watchdog (macro on, WDOG_LIMIT=64): force busy=1 permanently → done[grantId] 64 cycles after WAIT entry, error=1 and held; the next grant proceeds normally.

Source files
------------

// File: rtl/busy_ctr_arbiter.sv
// -----------------------------------------------------------------------------
// busy_ctr_arbiter
//
// Round-robin scheduler that serializes NUM_REQ requesters onto one shared
// BusyCtr-style busy timer. Each requester posts a one-cycle request. The
// arbiter latches it as pending and picks a winner in round-robin order. It
// fires the timer's start method, follows the timer's busy output until it
// drops, then pulses done for the winner.
//
// Parameters:
//   NUM_REQ     number of requesters, 2..16
//   WDOG_LIMIT  watchdog expiry in cycles (used only with the watchdog macro)
//
// Ports:
//   CLK         clock, all state changes on its rising edge
//   nRST        asynchronous active-low reset
//   req__ENA    per-requester request strobe, honoured when req__RDY is high
//   req__RDY    per-requester ready (= not pending)
//   done        one-cycle completion pulse to the granted requester
//   grantId     index of the current or most recent grant
//   start__ENA  fires the timer's start method (combinational from state)
//   start__RDY  timer idle (counter == 0)
//   busy        timer busy output
//   error       sticky watchdog flag (tied to 0 without the watchdog)
//
// Configuration:
//   BUSY_ARB_WATCHDOG_EN  when defined, a grant that stays in WAIT/RUN for
//                         WDOG_LIMIT cycles is force-completed and error is set
//                         until reset. When undefined, RUN waits for busy to
//                         drop indefinitely and error is constant 0.
// -----------------------------------------------------------------------------
module busy_ctr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WDOG_LIMIT = 64
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         req__ENA,
  output logic [NUM_REQ-1:0]         req__RDY,
  output logic [NUM_REQ-1:0]         done,
  output logic [$clog2(NUM_REQ)-1:0] grantId,
  output logic                       start__ENA,
  input  logic                       start__RDY,
  input  logic                       busy,
  output logic                       error
);

  localparam int GW = $clog2(NUM_REQ);

  // Elaboration-time guard on the parameter ranges.
  if (NUM_REQ < 2 || NUM_REQ > 16 || WDOG_LIMIT < 1) begin : g_bad_params
    $error("busy_ctr_arbiter: NUM_REQ must be 2..16 and WDOG_LIMIT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,   // waiting for any pending request
    ST_ISSUE,  // firing start as soon as the timer is idle
    ST_WAIT,   // single cycle right after start: busy tells RUN vs zero-length
    ST_RUN     // timer running, wait for busy to drop
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] pending;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      winner;
  logic [GW-1:0]      scan_idx;
  logic               complete;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] clear_mask;

  // ---------------------------------------------------------------------------
  // Request bookkeeping
  // ---------------------------------------------------------------------------
  // A request is only honoured when its ready bit is high, i.e. not already
  // pending, so a request can never be duplicated.
  assign req__RDY   = ~pending;
  assign accept     = req__ENA & ~pending;
  // Completion retires exactly the granted requester's pending bit.
  assign clear_mask = complete ? (NUM_REQ'(1) << grantId) : '0;

  // The start strobe is decoded from state so that an asynchronous reset
  // removes it immediately, without waiting for a clock edge.
  assign start__ENA = (state == ST_ISSUE) && start__RDY;

  // ---------------------------------------------------------------------------
  // Round-robin winner search, starting at last_grant+1 and wrapping.
  // Scanning from the farthest offset down to the nearest lets the nearest
  // pending requester win without an explicit "found" flag.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in always_comb gets a default before any branch;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    winner   = last_grant;
    scan_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      scan_idx = GW'((int'(last_grant) + off) % NUM_REQ);
      if (pending[scan_idx]) begin
        winner = scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion detect: the timer reports busy low in WAIT (zero-length run)
  // or in RUN, or the watchdog expires.
  // ---------------------------------------------------------------------------
`ifdef BUSY_ARB_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_LIMIT + 1);

  logic [WCW-1:0] wdog_cnt;
  logic           wdog_expire;

  always_comb begin
    complete    = 1'b0;
    wdog_expire = 1'b0;
    if (state == ST_WAIT || state == ST_RUN) begin
      if (!busy) begin
        complete = 1'b1;
      end else if (wdog_cnt == WCW'(WDOG_LIMIT - 1)) begin
        // The counter reaches WDOG_LIMIT at this edge: force completion.
        complete    = 1'b1;
        wdog_expire = 1'b1;
      end
    end
  end

  // Counter clears at the start edge (entry to WAIT) and counts every cycle
  // spent in WAIT or RUN. The error flag is sticky until reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog_cnt <= '0;
      error    <= 1'b0;
    end else begin
      if (start__ENA) begin
        wdog_cnt <= '0;
      end else if (state == ST_WAIT || state == ST_RUN) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_expire) begin
        error <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    complete = 1'b0;
    if ((state == ST_WAIT || state == ST_RUN) && !busy) begin
      complete = 1'b1;
    end
  end

  assign error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered grantId / done / pending
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= ST_IDLE;
      pending    <= '0;
      done       <= '0;
      grantId    <= '0;
      // First search after reset begins at index 0.
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      // Set and clear never hit the same bit: set needs !pending, clear needs
      // the granted bit, which is pending throughout its grant.
      pending <= (pending | accept) & ~clear_mask;
      done    <= clear_mask;

      case (state)
        ST_IDLE: begin
          if (|pending) begin
            grantId <= winner;
            state   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (start__RDY) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT, ST_RUN: begin
          if (complete) begin
            last_grant <= grantId;
            state      <= ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
